// File: rtl/hack_pkg.sv
// Shared Hack CPU definitions: instruction field positions, widths, sequencer states.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package hack_pkg;

  localparam int WORD_W    = 16;
  localparam int ALU_CTL_W = 6;

  // Instruction word layout
  localparam int IR_TYPE_BIT = 15;  // 0 = A-instruction, 1 = C-instruction
  localparam int IR_A_BIT    = 12;  // selects M instead of A as ALU y operand
  localparam int IR_COMP_HI  = 11;
  localparam int IR_COMP_LO  = 6;
  localparam int IR_DEST_HI  = 5;   // dest = {d1:A, d2:D, d3:M}
  localparam int IR_DEST_LO  = 3;
  localparam int IR_JUMP_HI  = 2;   // jump = {j1:lt, j2:eq, j3:gt}
  localparam int IR_JUMP_LO  = 0;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_READ   = 3'd2,
    ST_EXEC   = 3'd3,
    ST_WRITE  = 3'd4
  } state_e;

endpackage

// File: rtl/hack_jump_eval.sv
// Jump decision from the jjj field and ALU zero/negative flags.
// Latency: purely combinational.
// Backpressure: none.
module hack_jump_eval
  import hack_pkg::*;
(
  input  logic [IR_JUMP_HI-IR_JUMP_LO:0] jmp_i,
  input  logic                           zr_i,
  input  logic                           ng_i,
  output logic                           taken_o
);

  // lt / eq / gt conditions; all three set gives an unconditional jump
  assign taken_o = (jmp_i[2] & ng_i)
                 | (jmp_i[1] & zr_i)
                 | (jmp_i[0] & ~zr_i & ~ng_i);

endmodule

// File: rtl/hack_control_unit.sv
// Multi-cycle Hack sequencer: fetch, decode, optional M read, execute, optional M write.
// Latency: fetch ack -> next fetch is 1 cycle (A), 2 cycles (C), +1+waits per M access.
// Backpressure: each request is held with stable address/data until its ack; no timeout.
module hack_control_unit
  import hack_pkg::*;
#(
  parameter int PC_W     = 15,
  parameter int RESET_PC = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 instr_req,
  output logic [PC_W-1:0]      instr_addr,
  input  logic                 instr_ack,
  input  logic [WORD_W-1:0]    instr_data,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [PC_W-1:0]      mem_addr,
  output logic [WORD_W-1:0]    mem_wdata,
  input  logic                 mem_ack,
  input  logic [WORD_W-1:0]    mem_rdata,
  output logic [WORD_W-1:0]    alu_x,
  output logic [WORD_W-1:0]    alu_y,
  output logic [ALU_CTL_W-1:0] alu_ctl,
  input  logic [WORD_W-1:0]    alu_out,
  input  logic                 alu_zr,
  input  logic                 alu_ng,
  output logic [PC_W-1:0]      pc
);

  state_e state_q, state_d;

  logic [WORD_W-1:0] ir_q, ir_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] d_q, d_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [WORD_W-1:0] r_q, r_d;     // ALU result held across the M write
  logic [WORD_W-1:0] m_q, m_d;     // M operand captured by the read
  logic              zr_q, zr_d;
  logic              ng_q, ng_d;

  logic [IR_DEST_HI-IR_DEST_LO:0] dest;
  logic [IR_JUMP_HI-IR_JUMP_LO:0] jmp;
  logic              is_c;
  logic              a_sel;
  logic              commit;
  logic [WORD_W-1:0] res;
  logic              flag_zr;
  logic              flag_ng;
  logic              taken;
  logic [PC_W-1:0]   pc_inc;

  // IR[14:13] carry no meaning for this core
  logic unused_ir_bits;
  assign unused_ir_bits = ^ir_q[14:13];

  assign dest   = ir_q[IR_DEST_HI:IR_DEST_LO];
  assign jmp    = ir_q[IR_JUMP_HI:IR_JUMP_LO];
  assign is_c   = ir_q[IR_TYPE_BIT];
  assign a_sel  = ir_q[IR_A_BIT];
  assign pc_inc = pc_q + PC_W'(1);

  // Without an M write the commit happens in EXEC, so the result and flags
  // come straight off the ALU; after a write they come from the latches.
  assign commit  = ((state_q == ST_EXEC) && !dest[0])
                 || ((state_q == ST_WRITE) && mem_ack);
  assign res     = (state_q == ST_EXEC) ? alu_out : r_q;
  assign flag_zr = (state_q == ST_EXEC) ? alu_zr  : zr_q;
  assign flag_ng = (state_q == ST_EXEC) ? alu_ng  : ng_q;

  hack_jump_eval u_jump_eval (
    .jmp_i   (jmp),
    .zr_i    (flag_zr),
    .ng_i    (flag_ng),
    .taken_o (taken)
  );

  // State register; reset also abandons any outstanding request
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: advance on acks, branch on instruction type, a-bit and d3
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_FETCH:  if (instr_ack) state_d = ST_DECODE;
      ST_DECODE: begin
        if (!is_c)      state_d = ST_FETCH;
        else if (a_sel) state_d = ST_READ;
        else            state_d = ST_EXEC;
      end
      ST_READ:   if (mem_ack) state_d = ST_EXEC;
      ST_EXEC:   state_d = dest[0] ? ST_WRITE : ST_FETCH;
      ST_WRITE:  if (mem_ack) state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Bus strobes follow the state directly and are forced low while in reset
  always_comb begin
    instr_req = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    if (!reset) begin
      case (state_q)
        ST_FETCH: instr_req = 1'b1;
        ST_READ:  mem_req   = 1'b1;
        ST_WRITE: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Datapath next-state: IR/M capture on acks, A-load, result latch, commit
  always_comb begin
    ir_d = ir_q;
    a_d  = a_q;
    d_d  = d_q;
    pc_d = pc_q;
    r_d  = r_q;
    m_d  = m_q;
    zr_d = zr_q;
    ng_d = ng_q;
    case (state_q)
      ST_FETCH:  if (instr_ack) ir_d = instr_data;
      ST_DECODE: begin
        if (!is_c) begin
          a_d  = {1'b0, ir_q[WORD_W-2:0]};
          pc_d = pc_inc;
        end
      end
      ST_READ:   if (mem_ack) m_d = mem_rdata;
      ST_EXEC: begin
        r_d  = alu_out;
        zr_d = alu_zr;
        ng_d = alu_ng;
      end
      default: ;
    endcase
    // Jump target is the A value from before this instruction's own A write
    if (commit) begin
      if (dest[2]) a_d = res;
      if (dest[1]) d_d = res;
      pc_d = taken ? a_q[PC_W-1:0] : pc_inc;
    end
  end

  // Architectural and holding registers
  always_ff @(posedge clk) begin
    if (reset) begin
      ir_q <= '0;
      a_q  <= '0;
      d_q  <= '0;
      pc_q <= PC_W'(RESET_PC);
      r_q  <= '0;
      m_q  <= '0;
      zr_q <= 1'b0;
      ng_q <= 1'b0;
    end else begin
      ir_q <= ir_d;
      a_q  <= a_d;
      d_q  <= d_d;
      pc_q <= pc_d;
      r_q  <= r_d;
      m_q  <= m_d;
      zr_q <= zr_d;
      ng_q <= ng_d;
    end
  end

  assign instr_addr = pc_q;
  assign mem_addr   = a_q[PC_W-1:0];
  assign mem_wdata  = r_q;
  assign alu_x      = d_q;
  assign alu_y      = a_sel ? m_q : a_q;
  assign alu_ctl    = ir_q[IR_COMP_HI:IR_COMP_LO];
  assign pc         = pc_q;

  // The two buses are never requested together
  a_one_req: assert property (@(posedge clk) disable iff (reset)
    !(instr_req && mem_req));

  // A pending data request keeps its address and direction until acked
  a_mem_hold: assert property (@(posedge clk) disable iff (reset)
    (mem_req && !mem_ack) |=> (mem_req && $stable(mem_addr) && $stable(mem_we)));

endmodule

// File: tb/tb_hack_control_unit.sv
module tb_hack_control_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_req;
  logic [14:0] instr_addr;
  logic        instr_ack;
  logic [15:0] instr_data;
  logic        mem_req;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic [15:0] alu_x;
  logic [15:0] alu_y;
  logic [5:0]  alu_ctl;
  logic [15:0] alu_out;
  logic        alu_zr;
  logic        alu_ng;
  logic [14:0] pc;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  hack_control_unit #(.PC_W(15), .RESET_PC(0)) dut (
    .clk        (clk),
    .reset      (reset),
    .instr_req  (instr_req),
    .instr_addr (instr_addr),
    .instr_ack  (instr_ack),
    .instr_data (instr_data),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata),
    .alu_x      (alu_x),
    .alu_y      (alu_y),
    .alu_ctl    (alu_ctl),
    .alu_out    (alu_out),
    .alu_zr     (alu_zr),
    .alu_ng     (alu_ng),
    .pc         (pc)
  );

  // Hack ALU as defined by the ISA
  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0000 : x;
    if (c[4]) xx = ~xx;
    yy = c[3] ? 16'h0000 : y;
    if (c[2]) yy = ~yy;
    o = c[1] ? (xx + yy) : (xx & yy);
    if (c[0]) o = ~o;
    return o;
  endfunction

  always_comb begin
    alu_out = hack_alu(alu_x, alu_y, alu_ctl);
    alu_zr  = (alu_out == 16'h0000);
    alu_ng  = alu_out[15];
  end

  // Reference machine state
  logic [15:0] m_a, m_d;
  int          m_pc;
  logic [15:0] prev_ins;
  bit          have_prev;
  int          ack_cyc;
  int          exp_gap;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Wait for the next fetch request and compare architectural state there
  task automatic sync_fetch(input string tag);
    int n;
    bit stray;
    n = 0;
    stray = 0;
    while (instr_req !== 1'b1 && n < 40) begin
      if (mem_req === 1'b1) stray = 1;
      instr_ack = 1'($urandom_range(0, 1));
      mem_ack   = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    instr_ack = 1'b0;
    mem_ack   = 1'b0;
    chk({tag, "_instr_req"}, 32'(instr_req), 32'd1);
    if (instr_req !== 1'b1) return;
    chk({tag, "_stray_mem_req"}, 32'(stray), 32'd0);
    chk({tag, "_instr_addr"}, 32'(instr_addr), 32'(m_pc));
    chk({tag, "_pc"}, 32'(pc), 32'(m_pc));
    chk({tag, "_D"}, 32'(alu_x), 32'(m_d));
    chk({tag, "_A"}, 32'(mem_addr), 32'(m_a[14:0]));
    if (have_prev) begin
      chk({tag, "_latency"}, 32'(cyc - ack_cyc - 1), 32'(exp_gap));
      chk({tag, "_alu_ctl"}, 32'(alu_ctl), 32'(prev_ins[11:6]));
    end
  endtask

  // Present an instruction after fw wait cycles; starts with instr_req high
  task automatic do_fetch(input logic [15:0] ins, input int fw);
    bit stable;
    stable = 1;
    for (int i = 0; i <= fw; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (!(instr_req === 1'b1 && mem_req === 1'b0 && 32'(instr_addr) == 32'(m_pc))) stable = 0;
      end
      instr_ack  = (i == fw);
      instr_data = (i == fw) ? ins : 16'($urandom);
      mem_ack    = 1'($urandom_range(0, 1));
    end
    ack_cyc = cyc;
    @(negedge clk);
    instr_ack = 1'b0;
    mem_ack   = 1'b0;
    if (fw > 0) chk("fetch_hold", 32'(stable), 32'd1);
  endtask

  // Serve one data access with w wait cycles
  task automatic mem_phase(input bit we, input int w, input logic [15:0] rdata,
                           input logic [15:0] exp_wdata);
    int n;
    bit stable;
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      instr_ack = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    instr_ack = 1'b0;
    chk(we ? "wr_req" : "rd_req", 32'(mem_req), 32'd1);
    if (mem_req !== 1'b1) return;
    chk(we ? "wr_we" : "rd_we", 32'(mem_we), 32'(we));
    chk(we ? "wr_addr" : "rd_addr", 32'(mem_addr), 32'(m_a[14:0]));
    chk("bus_exclusive", 32'(instr_req), 32'd0);
    if (we) chk("wr_data", 32'(mem_wdata), 32'(exp_wdata));
    stable = 1;
    for (int i = 0; i <= w; i++) begin
      if (i > 0) begin
        @(negedge clk);
        if (!(mem_req === 1'b1 && mem_we === we && mem_addr === m_a[14:0]
              && (!we || mem_wdata === exp_wdata))) stable = 0;
      end
      mem_ack   = (i == w);
      mem_rdata = (i == w) ? rdata : 16'($urandom);
    end
    @(negedge clk);
    mem_ack = 1'b0;
    if (w > 0) chk(we ? "wr_hold" : "rd_hold", 32'(stable), 32'd1);
    chk(we ? "wr_req_drop" : "rd_req_drop", 32'(mem_req), 32'd0);
  endtask

  // Execute one instruction on the DUT and advance the reference machine
  task automatic run_instr(input logic [15:0] ins, input int fw, input int rw,
                           input int ww, input logic [15:0] rdata);
    logic [15:0] y, out, old_a;
    int sv;
    bit taken;
    do_fetch(ins, fw);
    if (!ins[15]) begin
      m_a     = {1'b0, ins[14:0]};
      m_pc    = (m_pc + 1) % 32768;
      exp_gap = 1;
    end else begin
      y     = ins[12] ? rdata : m_a;
      out   = hack_alu(m_d, y, ins[11:6]);
      sv    = int'($signed(out));
      taken = (ins[2] && sv < 0) || (ins[1] && sv == 0) || (ins[0] && sv > 0);
      if (ins[12]) mem_phase(1'b0, rw, rdata, 16'h0000);
      if (ins[3])  mem_phase(1'b1, ww, 16'h0000, out);
      exp_gap = 2 + (ins[12] ? 1 + rw : 0) + (ins[3] ? 1 + ww : 0);
      old_a = m_a;
      if (ins[5]) m_a = out;
      if (ins[4]) m_d = out;
      m_pc = taken ? int'(old_a[14:0]) : (m_pc + 1) % 32768;
    end
    prev_ins  = ins;
    have_prev = 1;
  endtask

  typedef struct {
    logic [15:0] ins;
    int          fw;
    int          rw;
    int          ww;
    logic [15:0] rdata;
    logic [15:0] exp_a;
    logic [15:0] exp_d;
    int          exp_pc;
  } vec_t;

  localparam int NV = 15;
  vec_t tbl[NV];

  initial begin
    int n;
    logic [15:0] ins;

    tbl[0]  = '{16'h0005, 0, 0, 0, 16'h0000, 16'h0005, 16'h0000, 1};
    tbl[1]  = '{16'hEC10, 1, 0, 0, 16'h0000, 16'h0005, 16'h0005, 2};
    tbl[2]  = '{16'h0010, 0, 0, 0, 16'h0000, 16'h0010, 16'h0005, 3};
    tbl[3]  = '{16'hE7C8, 0, 0, 3, 16'h0000, 16'h0010, 16'h0005, 4};
    tbl[4]  = '{16'h0020, 2, 0, 0, 16'h0000, 16'h0020, 16'h0005, 5};
    tbl[5]  = '{16'hFC10, 0, 1, 0, 16'h8000, 16'h0020, 16'h8000, 6};
    tbl[6]  = '{16'h0100, 0, 0, 0, 16'h0000, 16'h0100, 16'h8000, 7};
    tbl[7]  = '{16'hE304, 0, 0, 0, 16'h0000, 16'h0100, 16'h8000, 32'h100};
    tbl[8]  = '{16'h0005, 0, 0, 0, 16'h0000, 16'h0005, 16'h8000, 32'h101};
    tbl[9]  = '{16'hEC10, 0, 0, 0, 16'h0000, 16'h0005, 16'h0005, 32'h102};
    tbl[10] = '{16'h0100, 0, 0, 0, 16'h0000, 16'h0100, 16'h0005, 32'h103};
    tbl[11] = '{16'hE304, 1, 0, 0, 16'h0000, 16'h0100, 16'h0005, 32'h104};
    tbl[12] = '{16'h7FFF, 0, 0, 0, 16'h0000, 16'h7FFF, 16'h0005, 32'h105};
    tbl[13] = '{16'hEA87, 0, 0, 0, 16'h0000, 16'h7FFF, 16'h0005, 32'h7FFF};
    tbl[14] = '{16'h1234, 0, 0, 0, 16'h0000, 16'h1234, 16'h0005, 0};

    reset      = 1'b1;
    instr_ack  = 1'b0;
    instr_data = 16'h0000;
    mem_ack    = 1'b0;
    mem_rdata  = 16'h0000;
    m_a = 16'h0000; m_d = 16'h0000; m_pc = 0;
    prev_ins = 16'h0000; have_prev = 0; ack_cyc = 0; exp_gap = 0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_instr_req", 32'(instr_req), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("first_cycle_instr_req", 32'(instr_req), 32'd1);
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_D", 32'(alu_x), 32'd0);
    chk("rst_A", 32'(alu_y), 32'd0);
    chk("rst_alu_ctl", 32'(alu_ctl), 32'd0);
    sync_fetch("boot");

    // Directed program from the table
    for (int i = 0; i < NV; i++) begin
      run_instr(tbl[i].ins, tbl[i].fw, tbl[i].rw, tbl[i].ww, tbl[i].rdata);
      sync_fetch($sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
      chk($sformatf("tbl%0d_D", i), 32'(alu_x), 32'(tbl[i].exp_d));
      chk($sformatf("tbl%0d_A", i), 32'(mem_addr), 32'(tbl[i].exp_a[14:0]));
    end

    // Reset while a write is pending: M=D with ack held low
    do_fetch(16'hE308, 0);
    n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rstwr_req", 32'(mem_req), 32'd1);
    chk("rstwr_we", 32'(mem_we), 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rstwr_mem_req", 32'(mem_req), 32'd0);
    chk("rstwr_instr_req", 32'(instr_req), 32'd1);
    chk("rstwr_pc", 32'(pc), 32'd0);
    chk("rstwr_D", 32'(alu_x), 32'd0);
    chk("rstwr_A", 32'(mem_addr), 32'd0);
    m_a = 16'h0000; m_d = 16'h0000; m_pc = 0; have_prev = 0;
    sync_fetch("post_rst");

    // Random programs against the reference machine
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) == 0) ins = {1'b0, 15'($urandom)};
      else                           ins = 16'($urandom) | 16'h8000;
      run_instr(ins, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), 16'($urandom));
      sync_fetch("rnd");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Overall time limit
  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete, got no end expected end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hack_control_unit.md
# hack_control_unit

Multi-cycle control unit for the Hack CPU. It fetches 16-bit Hack instructions over a request/acknowledge bus and holds the A, D and PC registers. It drives the control bits and operands of the combinational ALU instance, and sequences data-memory reads and writes for M operands and destinations. The block sits between the instruction/data memory ports and the ALU, which stays a separate instance wired alongside it.

## Interface
- `PC_W`, 15, width of PC, A address field and memory addresses.
- `RESET_PC`, 0, PC value loaded on reset.

- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instr_req` out 1: instruction fetch request. `instr_addr` out PC_W: fetch address (= PC).
- `instr_ack` in 1: fetch complete this cycle. `instr_data` in 16: instruction, valid when ack.
- `mem_req` out 1: data access request. `mem_we` out 1: 1 = write. `mem_addr` out PC_W: = A[PC_W-1:0]. `mem_wdata` out 16: write data.
- `mem_ack` in 1: access complete this cycle. `mem_rdata` in 16: read data, valid when ack.
- `alu_x` out 16: = D. `alu_y` out 16: = IR[12] ? M latch : A. `alu_ctl` out 6: {zx,nx,zy,ny,f,no} = IR[11:6].
- `alu_out` in 16, `alu_zr` in 1, `alu_ng` in 1: ALU results, combinational from the outputs above.
- `pc` out PC_W: current PC, for debug.

## Operation
- FSM states: FETCH, DECODE, READ, EXEC, WRITE.
- FETCH: `instr_req`=1 and `instr_addr`=PC. On ack, IR<=instr_data and go to DECODE.
- DECODE, A-instruction (IR[15]=0): A<=IR with bit 15 forced to 0; PC<=PC+1; go to FETCH.
- DECODE, C-instruction: if IR[12]=1, go to READ; else go to EXEC. IR[14:13] are ignored.
- READ: `mem_req`=1, `mem_we`=0, addr=A. On ack, the M latch captures `mem_rdata`; go to EXEC.
- EXEC: R<=`alu_out`; flags<={`alu_zr`,`alu_ng`}.
  - If d3 (IR[3]) is set: go to WRITE.
  - Otherwise commit and go to FETCH.
- WRITE: `mem_req`=1, `mem_we`=1, addr=A before update, `mem_wdata`=R. On ack, commit and go to FETCH.
- Commit is one edge:
  - A<=R if IR[5].
  - D<=R if IR[4].
  - PC<= taken ? A before update : PC+1.
- Jump condition: taken = (IR[2]&ng) | (IR[1]&zr) | (IR[0]&~zr&~ng). jjj=111 is an unconditional jump. In EXEC without d3 the flags come live from the ALU; in WRITE they come from the latch.
- PC wraps: (2^PC_W-1)+1 -> 0. A loads the full 16 bits from R.

## Timing
- Handshake:
  - Requests assert on entering the state, with address and data stable until the ack cycle.
  - Transfer completes on the edge where ack=1; the request drops the next cycle.
  - Zero-wait (ack in the first request cycle) is legal.
  - Ack while the request is low is ignored.
- Latency from the fetch ack edge to the next `instr_req` cycle:
  - A-instruction: 1 cycle.
  - C-instruction with no M: 2 cycles.
  - Each M read and each M write adds 1 cycle plus wait cycles.
- Only one of `instr_req` and `mem_req` is high at a time.
- Reset value of every output and register:
  - `instr_req`=0, `mem_req`=0, `mem_we`=0.
  - PC=RESET_PC; A, D, IR, R and the M latch = 0; state=FETCH.
  - `instr_req`=1 in the first cycle after reset deasserts.
- Reset mid-transaction abandons the outstanding request: the request is low the next cycle and no commit occurs. The memory must tolerate an abandoned request.
- The ALU is a combinational path from the outputs of this block back to its inputs. It must close in one cycle; the block adds no register on it.

## Structure
- Shared package `hack_pkg` holds:
  - the state enum;
  - the IR field positions: type bit 15, a-bit 12, comp 11:6, dest 5:3, jump 2:0;
  - `ALU_CTL_W`=6 and `WORD_W`=16.
- Sub-module `hack_jump_eval`: a combinational function of jjj, zr and ng giving taken. It is reused by the future pipelined core.
- The ALU is instantiated at the CPU top level, not inside this block.

## Test plan
- Reset, then fetch at 0x0000 returning 0x0005 with zero-wait ack -> A=0x0005, PC=1; next `instr_req` with addr=1 two cycles after the first request.
- 0xEC10 (D=A) with A=5 -> `alu_ctl`=6'b110000, D=5, PC=2, no `mem_req`.
- A=0x0010, D=5, then 0xE7C8 (M=D+1) with `mem_ack` held low 3 cycles -> `mem_req`=1, `mem_we`=1, addr 0x0010, wdata 0x0006 stable all 4 cycles; D unchanged; PC+1 after ack.
- 0xFC10 (D=M) with A=0x0020 and `mem_rdata`=0x8000 -> read at 0x0020, D=0x8000.
- A=0x0100, then 0xE304 (D;JLT):
  - D=0x8000 -> PC=0x0100.
  - D=5 -> PC=old+1.
  - A-instruction at PC=0x7FFF -> PC=0.
- Reset asserted during WRITE with ack low -> next cycle `mem_req`=0, PC=0, A=D=0; then fetch from 0.
